adc_serial_capture: RTL and testbench

Parametrised successor to the single-channel AD7643 serial-slave readout. It drives shared CS/CNVST/SCLK to NCH ADCs and shifts NBITS per channel from the per-channel SDOUT lines. It uses a BUSY handshake with timeout instead of fixed counter slots, and writes one word per channel per frame into the sample memory. It sits between the USB command decoder (START/STOP/NSAMP) and the dmem write port.

---
 rtl/adc_serial_capture.sv | 190 +++++++++++++++++++
 tb/tb_adc_serial_capture.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_capture.sv
// adc_serial_capture: drives shared CS/CNVST/SCLK to NCH serial ADCs, one word per channel per frame to memory.
// Latency: frame = CNV_LOW + BUSY time + 2*SCLK_HALF*NBITS + NCH cycles; BUSY wait bounded by TMO cycles.
// Backpressure: none, memory takes a write every cycle; define ADC_TEST_PATTERN_EN to add the TPAT port.
module adc_serial_capture #(
    parameter int NCH       = 2,
    parameter int NBITS     = 18,
    parameter int ADDR_W    = 14,
    parameter int SCLK_HALF = 6,
    parameter int CNV_LOW   = 5,
    parameter int TMO       = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              STOP,
    input  logic [ADDR_W-1:0] NSAMP,
    input  logic [NCH-1:0]    ADBUSY,
    input  logic [NCH-1:0]    ADSDOUT,
`ifdef ADC_TEST_PATTERN_EN
    input  logic              TPAT,
`endif
    output logic              ADCS,
    output logic              ADCNVST,
    output logic              ADSCLK,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [NBITS-1:0]  WR_DATA,
    output logic              ACTIVE,
    output logic              DONE,
    output logic              ERR,
    output logic [ADDR_W-1:0] FRAMES
);
    localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BW     = $clog2(NBITS + 1);
    localparam int CMAX_A = (CNV_LOW > SCLK_HALF) ? CNV_LOW : SCLK_HALF;
    localparam int CMAX   = (TMO > CMAX_A) ? TMO : CMAX_A;
    localparam int CW     = $clog2(CMAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_CNV, S_WAIT_BUSY, S_SHIFT, S_STORE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bit_cnt;
    logic [CHW-1:0]    ch;
    logic [NCH-1:0]    seen;
    logic              stop_lat;
    logic [ADDR_W-1:0] nsamp_q;
    logic [NBITS-1:0]  sr [NCH];
`ifdef ADC_TEST_PATTERN_EN
    logic              tpat_q;
`endif

    logic [ADDR_W-1:0] frames_inc;
    logic [CHW-1:0]    ch_nxt;
    logic [CHW-1:0]    ch_sel;
    logic [NBITS-1:0]  word_sel;

    // Word for the next write: channel 0 when leaving SHIFT, else the following channel.
    always_comb begin
        frames_inc = (&FRAMES) ? FRAMES : FRAMES + 1'b1;
        ch_nxt     = ch + 1'b1;
        ch_sel     = (state == S_STORE) ? ch_nxt : '0;
        word_sel   = sr[ch_sel];
`ifdef ADC_TEST_PATTERN_EN
        if (tpat_q)
            word_sel = NBITS'({ch_sel, FRAMES});
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            ADCS     <= 1'b1;
            ADCNVST  <= 1'b1;
            ADSCLK   <= 1'b0;
            WR_EN    <= 1'b0;
            WR_ADDR  <= '0;
            WR_DATA  <= '0;
            ACTIVE   <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            FRAMES   <= '0;
            cnt      <= '0;
            bit_cnt  <= '0;
            ch       <= '0;
            seen     <= '0;
            stop_lat <= 1'b0;
            nsamp_q  <= '0;
`ifdef ADC_TEST_PATTERN_EN
            tpat_q   <= 1'b0;
`endif
            for (int i = 0; i < NCH; i++)
                sr[i] <= '0;
        end else begin
            DONE <= 1'b0;
            if (ACTIVE && STOP)
                stop_lat <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (START && !STOP) begin
                        ERR      <= 1'b0;
                        FRAMES   <= '0;
                        WR_ADDR  <= '0;
                        stop_lat <= 1'b0;
                        nsamp_q  <= NSAMP;
`ifdef ADC_TEST_PATTERN_EN
                        tpat_q   <= TPAT;
`endif
                        ACTIVE   <= 1'b1;
                        ADCNVST  <= 1'b0;
                        cnt      <= '0;
                        state    <= S_CNV;
                    end
                end
                S_CNV: begin
                    if (cnt == CW'(CNV_LOW - 1)) begin
                        ADCNVST <= 1'b1;
                        cnt     <= '0;
                        seen    <= '0;
                        state   <= S_WAIT_BUSY;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_BUSY: begin
                    seen <= seen | ADBUSY;
                    // Every channel must have shown BUSY before an all-low counts as done.
                    if ((&seen) && (ADBUSY == '0)) begin
                        ADCS    <= 1'b0;
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= S_SHIFT;
                    end else if (cnt == CW'(TMO - 1)) begin
                        ERR    <= 1'b1;
                        ACTIVE <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (cnt == CW'(SCLK_HALF - 1)) begin
                        cnt <= '0;
                        if (!ADSCLK) begin
                            ADSCLK <= 1'b1;
                            for (int i = 0; i < NCH; i++)
                                sr[i] <= {sr[i][NBITS-2:0], ADSDOUT[i]};
                        end else begin
                            ADSCLK <= 1'b0;
                            if (bit_cnt == BW'(NBITS - 1)) begin
                                ADCS    <= 1'b1;
                                ch      <= '0;
                                WR_EN   <= 1'b1;
                                WR_DATA <= word_sel;
                                state   <= S_STORE;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STORE: begin
                    WR_ADDR <= WR_ADDR + 1'b1;
                    if (ch == CHW'(NCH - 1)) begin
                        WR_EN  <= 1'b0;
                        FRAMES <= frames_inc;
                        if ((nsamp_q != '0) && (frames_inc == nsamp_q)) begin
                            DONE   <= 1'b1;
                            ACTIVE <= 1'b0;
                            state  <= S_IDLE;
                        end else if (stop_lat || STOP) begin
                            ACTIVE <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            ADCNVST <= 1'b0;
                            cnt     <= '0;
                            state   <= S_CNV;
                        end
                    end else begin
                        ch      <= ch_nxt;
                        WR_DATA <= word_sel;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_serial_capture.sv
// Bench for adc_serial_capture: behavioural ADC models with random data and BUSY timing, scenario table, reset corners.
module tb_adc_serial_capture;
    localparam int NCH = 2, NBITS = 18, ADDR_W = 4, SCLK_HALF = 6, CNV_LOW = 5, TMO = 255;
    localparam int WDEPTH = 64;
    localparam int BUDGET = 20000;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              START = 1'b0;
    logic              STOP = 1'b0;
    logic [ADDR_W-1:0] NSAMP = '0;
    logic [NCH-1:0]    ADBUSY = '0;
    logic [NCH-1:0]    ADSDOUT = '0;
`ifdef ADC_TEST_PATTERN_EN
    logic              TPAT = 1'b0;
`endif
    logic              ADCS, ADCNVST, ADSCLK, WR_EN, ACTIVE, DONE, ERR;
    logic [ADDR_W-1:0] WR_ADDR, FRAMES;
    logic [NBITS-1:0]  WR_DATA;

    adc_serial_capture #(.NCH(NCH), .NBITS(NBITS), .ADDR_W(ADDR_W), .SCLK_HALF(SCLK_HALF),
                         .CNV_LOW(CNV_LOW), .TMO(TMO)) dut (
        .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .NSAMP(NSAMP),
        .ADBUSY(ADBUSY), .ADSDOUT(ADSDOUT),
`ifdef ADC_TEST_PATTERN_EN
        .TPAT(TPAT),
`endif
        .ADCS(ADCS), .ADCNVST(ADCNVST), .ADSCLK(ADSCLK), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
        .WR_DATA(WR_DATA), .ACTIVE(ACTIVE), .DONE(DONE), .ERR(ERR), .FRAMES(FRAMES)
    );

    initial forever #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ADC model: each conversion draws a random word per channel; BUSY rises and falls with random timing.
    logic [NBITS-1:0] words [WDEPTH][NCH];
    int  conv_cnt = 0;
    int  cur_conv = 0;
    bit  stuck = 0;
    int  rise_cnt [NCH];
    int  hold_cnt [NCH];
    int  bitpos [NCH];
    logic cnv_prev = 1'b1;
    logic sclk_prev_m = 1'b0;

    initial begin : adc_model
        for (int i = 0; i < NCH; i++) begin
            rise_cnt[i] = 0; hold_cnt[i] = 0; bitpos[i] = 0;
        end
        forever begin
            @(negedge CLK);
            if (ADCNVST === 1'b0 && cnv_prev === 1'b1) begin
                cur_conv = conv_cnt % WDEPTH;
                for (int i = 0; i < NCH; i++) begin
                    words[cur_conv][i] = NBITS'($urandom);
                    if (!stuck) begin
                        rise_cnt[i] = $urandom_range(1, 3);
                        hold_cnt[i] = $urandom_range(8, 40);
                    end
                end
                conv_cnt++;
            end
            for (int i = 0; i < NCH; i++) begin
                if (rise_cnt[i] > 0) begin
                    rise_cnt[i]--;
                    if (rise_cnt[i] == 0) ADBUSY[i] = 1'b1;
                end else if (ADBUSY[i]) begin
                    if (hold_cnt[i] > 0) hold_cnt[i]--;
                    else begin
                        ADBUSY[i]  = 1'b0;
                        bitpos[i]  = NBITS - 1;
                        ADSDOUT[i] = words[cur_conv][i][NBITS-1];
                    end
                end
                if (ADSCLK === 1'b0 && sclk_prev_m === 1'b1 && bitpos[i] > 0) begin
                    bitpos[i]--;
                    ADSDOUT[i] = words[cur_conv][i][bitpos[i]];
                end
            end
            cnv_prev = ADCNVST;
            sclk_prev_m = ADSCLK;
        end
    end

    // Output monitor: memory writes, pulse counts and pin run lengths.
    int wa_q[$], wd_q[$], cs_q[$], rise_q[$], cnv_q[$];
    int done_cyc = 0, act_cyc = 0, cs_run = 0, rise_run = 0, cnv_run = 0;
    logic sclk_prev = 1'b0;

    initial begin : monitor
        forever begin
            @(negedge CLK);
            if (WR_EN === 1'b1) begin
                wa_q.push_back(int'(WR_ADDR));
                wd_q.push_back(int'(WR_DATA));
            end
            if (DONE === 1'b1) done_cyc++;
            if (ACTIVE === 1'b1) act_cyc++;
            if (ADCS === 1'b0) begin
                cs_run++;
                if (ADSCLK === 1'b1 && sclk_prev === 1'b0) rise_run++;
            end else if (cs_run != 0) begin
                cs_q.push_back(cs_run);
                rise_q.push_back(rise_run);
                cs_run = 0;
                rise_run = 0;
            end
            if (ADCNVST === 1'b0) cnv_run++;
            else if (cnv_run != 0) begin
                cnv_q.push_back(cnv_run);
                cnv_run = 0;
            end
            sclk_prev = ADSCLK;
        end
    end

    typedef struct {
        int nsamp;
        int stop_at;     // conversion index during whose shift STOP is pulsed; -1 = never
        bit stuck;
        int exp_frames;
        int exp_done;
        int exp_err;
        int exp_wr;
        int exp_act;     // expected ACTIVE-high cycles; 0 = not checked
    } vec_t;

    vec_t vecs [11];

    task automatic clear_mon();
        wa_q.delete(); wd_q.delete(); cs_q.delete(); rise_q.delete(); cnv_q.delete();
        done_cyc = 0; act_cyc = 0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int base;
        bit hit;
        int e;
        clear_mon();
        stuck = v.stuck;
        NSAMP = ADDR_W'(v.nsamp);
        base = conv_cnt;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk($sformatf("v%0d_active_after_start", idx), int'(ACTIVE), 1);
        chk($sformatf("v%0d_err_cleared", idx), int'(ERR), 0);
        if (v.stop_at >= 0) begin
            hit = 0;
            for (int g = 0; g < BUDGET && !hit && ACTIVE; g++) begin
                @(negedge CLK);
                if ((conv_cnt - base == v.stop_at + 1) && ADCS === 1'b0) hit = 1;
            end
            chk($sformatf("v%0d_stop_point_reached", idx), int'(hit), 1);
            if (hit) begin
                repeat (40) @(negedge CLK);
                STOP = 1'b1;
                @(negedge CLK);
                STOP = 1'b0;
            end
        end
        hit = 0;
        for (int g = 0; g < BUDGET && !hit; g++) begin
            if (ACTIVE === 1'b0) hit = 1;
            else @(negedge CLK);
        end
        chk($sformatf("v%0d_returns_idle", idx), int'(hit), 1);
        repeat (2) @(negedge CLK);
        chk($sformatf("v%0d_frames", idx), int'(FRAMES), v.exp_frames);
        chk($sformatf("v%0d_err", idx), int'(ERR), v.exp_err);
        chk($sformatf("v%0d_done_cycles", idx), done_cyc, v.exp_done);
        chk($sformatf("v%0d_write_count", idx), wa_q.size(), v.exp_wr);
        for (int k = 0; k < wa_q.size() && k < v.exp_wr; k++) begin
            e = int'(words[(base + k / NCH) % WDEPTH][k % NCH]);
            chk($sformatf("v%0d_wr%0d_addr", idx, k), wa_q[k], k % (1 << ADDR_W));
            chk($sformatf("v%0d_wr%0d_data", idx, k), wd_q[k], e);
        end
        foreach (cs_q[k]) chk($sformatf("v%0d_cs_low_len%0d", idx, k), cs_q[k], 2 * SCLK_HALF * NBITS);
        foreach (rise_q[k]) chk($sformatf("v%0d_sclk_rises%0d", idx, k), rise_q[k], NBITS);
        foreach (cnv_q[k]) chk($sformatf("v%0d_cnvst_low_len%0d", idx, k), cnv_q[k], CNV_LOW);
        chk($sformatf("v%0d_cs_frames", idx), cs_q.size(), v.exp_wr / NCH);
        if (v.exp_act != 0) chk($sformatf("v%0d_active_cycles", idx), act_cyc, v.exp_act);
    endtask

    initial begin : main
        int n0, r;
        bit hit;
        vecs[0] = '{3, -1, 0, 3, 1, 0, 6, 0};
        vecs[1] = '{0, 4, 0, 5, 0, 0, 10, 0};
        vecs[2] = '{0, -1, 1, 0, 0, 1, 0, CNV_LOW + TMO};
        vecs[3] = '{0, 9, 0, 10, 0, 0, 20, 0};
        vecs[4] = '{1, -1, 0, 1, 1, 0, 2, 0};
        vecs[5] = '{2, 0, 0, 1, 0, 0, 2, 0};
        vecs[6] = '{2, 1, 0, 2, 1, 0, 4, 0};
        vecs[7] = '{0, 17, 0, 15, 0, 0, 36, 0};
        for (int i = 8; i < 11; i++) begin
            r = $urandom_range(1, 5);
            vecs[i] = '{r, -1, 0, r, 1, 0, 2 * r, 0};
        end

        repeat (3) @(negedge CLK);
        chk("rst_adcs", int'(ADCS), 1);
        chk("rst_adcnvst", int'(ADCNVST), 1);
        chk("rst_adsclk", int'(ADSCLK), 0);
        chk("rst_wr_en", int'(WR_EN), 0);
        chk("rst_wr_addr", int'(WR_ADDR), 0);
        chk("rst_wr_data", int'(WR_DATA), 0);
        chk("rst_active", int'(ACTIVE), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_err", int'(ERR), 0);
        chk("rst_frames", int'(FRAMES), 0);
        RST = 1'b0;
        @(negedge CLK);

        // START together with STOP must be ignored.
        NSAMP = 4'd1;
        START = 1'b1; STOP = 1'b1;
        @(negedge CLK);
        START = 1'b0; STOP = 1'b0;
        chk("start_stop_active", int'(ACTIVE), 0);
        chk("start_stop_cnvst", int'(ADCNVST), 1);
        repeat (3) @(negedge CLK);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Reset in the middle of the second frame's shift.
        clear_mon();
        stuck = 0;
        NSAMP = '0;
        n0 = conv_cnt;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        hit = 0;
        for (int g = 0; g < BUDGET && !hit; g++) begin
            @(negedge CLK);
            if ((conv_cnt - n0 == 2) && ADCS === 1'b0) hit = 1;
        end
        chk("rst_mid_shift_reached", int'(hit), 1);
        repeat (30) @(negedge CLK);
        chk("rst_mid_frames_before", int'(FRAMES), 1);
        n0 = wa_q.size();
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_mid_adcs", int'(ADCS), 1);
        chk("rst_mid_adsclk", int'(ADSCLK), 0);
        chk("rst_mid_wr_en", int'(WR_EN), 0);
        chk("rst_mid_active", int'(ACTIVE), 0);
        chk("rst_mid_frames", int'(FRAMES), 0);
        RST = 1'b0;
        repeat (300) @(negedge CLK);
        chk("rst_mid_writes_before", n0, NCH);
        chk("rst_mid_no_later_writes", wa_q.size(), n0);
        chk("rst_mid_stays_idle", int'(ACTIVE), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
